// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl
// Host-side sequencer for the 4-tap FIR core. After cfg_start it resets the
// core, sends the mode word (always 0) and the coefficients (highest tap
// first). It then streams one sample per cycle from a small input FIFO into
// the core and returns each real sample's filter output with a valid strobe.
//
// Ports
//   clk        system clock, shared with the FIR core
//   reset_n    synchronous active-low reset
//   cfg_coef   packed taps; [BW_IN*i +: BW_IN] is tap i (tap 0 = newest sample)
//   cfg_start  one-cycle pulse: capture cfg_coef and (re)program the core
//   busy       high while the core is being programmed
//   s_data     signed input sample
//   s_valid    input sample valid
//   s_ready    sample accepted when s_valid && s_ready at a rising edge
//   fir_reset  core reset pin, active-high
//   fir_x      core data pins
//   fir_y      core output byte
//   m_data     captured filter output, held between strobes
//   m_valid    one-cycle strobe per accepted sample, no backpressure
module fir_stream_ctrl #(
   parameter int N_TAPS     = 4,
   parameter int BW_IN      = 6,
   parameter int BW_OUT     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [N_TAPS*BW_IN-1:0]   cfg_coef,
   input  logic                      cfg_start,
   output logic                      busy,
   input  logic [BW_IN-1:0]          s_data,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic                      fir_reset,
   output logic [BW_IN-1:0]          fir_x,
   input  logic [BW_OUT-1:0]         fir_y,
   output logic [BW_OUT-1:0]         m_data,
   output logic                      m_valid
);

   localparam int IW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] FRST = 3'd1;
   localparam logic [2:0] MODE = 3'd2;
   localparam logic [2:0] COEF = 3'd3;
   localparam logic [2:0] RUN  = 3'd4;

   logic [2:0]              state, state_n;
   logic [IW-1:0]           idx, idx_n;
   logic [N_TAPS*BW_IN-1:0] shadow;
   logic [BW_IN-1:0]        tap [N_TAPS];
   logic [BW_IN-1:0]        mem [FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr, rd_ptr;
   logic [CW-1:0]           count, count_n;
   logic                    tag0, tag1;
   logic                    restart, push, pop;
   logic                    fir_reset_d, busy_d, s_ready_d;
   logic [BW_IN-1:0]        fir_x_d;

   always_comb begin
      for (int unsigned i = 0; i < N_TAPS; i++) begin
         tap[i] = shadow[BW_IN*i +: BW_IN];
      end
   end

   always_comb begin
      restart = cfg_start && (state != IDLE);
      push    = s_valid && s_ready && !restart;
      pop     = (state == RUN) && (count != '0) && !restart;

      state_n = state;
      idx_n   = idx;
      case (state)
         IDLE: if (cfg_start) state_n = FRST;
         FRST: state_n = MODE;
         MODE: begin
            state_n = COEF;
            idx_n   = IW'(N_TAPS - 1);
         end
         COEF: begin
            if (idx == '0) state_n = RUN;
            else           idx_n   = idx - IW'(1);
         end
         RUN:     state_n = RUN;
         default: state_n = IDLE;
      endcase
      if (restart) state_n = FRST;

      count_n = count + CW'(push) - CW'(pop);
      if (restart) count_n = '0;

      // Outputs are registered, so they are decoded from the next state:
      // what the core sees in a cycle is what that cycle's state dictates.
      fir_reset_d = (state_n == IDLE) || (state_n == FRST);
      busy_d      = (state_n == FRST) || (state_n == MODE) || (state_n == COEF);
      s_ready_d   = (state_n == RUN) && (count_n < CW'(FIFO_DEPTH));

      fir_x_d = '0;
      if (state_n == COEF) fir_x_d = tap[idx_n];
      else if (pop)        fir_x_d = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         idx       <= '0;
         shadow    <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         tag0      <= 1'b0;
         tag1      <= 1'b0;
         fir_reset <= 1'b1;
         fir_x     <= '0;
         busy      <= 1'b0;
         s_ready   <= 1'b0;
         m_data    <= '0;
         m_valid   <= 1'b0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         if (cfg_start) shadow <= cfg_coef;

         count <= count_n;
         if (restart) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
         end

         // Tag pipe tracks real samples vs bubbles through the core's
         // one-cycle input register and one-cycle sum register.
         tag0 <= pop;
         tag1 <= tag0 && !restart;

         fir_reset <= fir_reset_d;
         fir_x     <= fir_x_d;
         busy      <= busy_d;
         s_ready   <= s_ready_d;

         m_valid <= tag1 && !restart;
         if (tag1 && !restart) m_data <= fir_y;
      end
   end

   // Storage needs no reset: occupancy is governed by count and the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_data;
   end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb_fir_stream_ctrl
// Directed self-checking bench for fir_stream_ctrl. A behavioural stand-in
// for the 4-tap FIR core sits on the fir_* pins: it takes the mode word and
// the coefficients from the pins, then computes a 13-bit signed sum and
// presents sum[12:5] on fir_y.
module tb_fir_stream_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [23:0] cfg_coef;
   logic        cfg_start;
   logic        busy;
   logic [5:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic        fir_reset;
   logic [5:0]  fir_x;
   logic [7:0]  fir_y;
   logic [7:0]  m_data;
   logic        m_valid;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int tp [4];
   int fed [$];
   logic [7:0] got_data [$];
   int         got_cyc  [$];

   fir_stream_ctrl #(
      .N_TAPS(4),
      .BW_IN(6),
      .BW_OUT(8),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .cfg_coef(cfg_coef),
      .cfg_start(cfg_start),
      .busy(busy),
      .s_data(s_data),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .fir_reset(fir_reset),
      .fir_x(fir_x),
      .fir_y(fir_y),
      .m_data(m_data),
      .m_valid(m_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (m_valid === 1'b1) begin
         got_data.push_back(m_data);
         got_cyc.push_back(cyc);
      end
   end

   // ---------------- core stand-in ----------------
   logic [2:0]        cph = 3'd0;
   logic signed [5:0] cc [4];
   logic signed [5:0] dl [3];
   logic [12:0]       csum = '0;

   function automatic logic [12:0] stub_sum(input logic signed [5:0] x, d0, d1, d2,
                                            input logic signed [5:0] k0, k1, k2, k3);
      int s;
      s = int'(x) * int'(k0) + int'(d0) * int'(k1) + int'(d1) * int'(k2) + int'(d2) * int'(k3);
      return 13'(s);
   endfunction

   always @(posedge clk) begin
      if (fir_reset === 1'b1) begin
         cph  <= 3'd0;
         csum <= '0;
         for (int i = 0; i < 3; i++) dl[i] <= '0;
      end else if (cph == 3'd0) begin
         cph <= 3'd1;
      end else if (cph < 3'd5) begin
         // highest tap arrives first and ends up in cc[3]
         cc[0] <= $signed(fir_x);
         cc[1] <= cc[0];
         cc[2] <= cc[1];
         cc[3] <= cc[2];
         cph   <= cph + 3'd1;
      end else begin
         csum  <= stub_sum($signed(fir_x), dl[0], dl[1], dl[2], cc[0], cc[1], cc[2], cc[3]);
         dl[0] <= $signed(fir_x);
         dl[1] <= dl[0];
         dl[2] <= dl[1];
      end
   end

   assign fir_y = csum[12:5];

   // ---------------- reference and helpers ----------------
   function automatic logic [7:0] ref_at(input int k);
      int s;
      logic [12:0] w;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         if (k - i >= 0) s += fed[k - i] * tp[i];
      end
      w = 13'(s);
      return w[12:5];
   endfunction

   function automatic logic [23:0] pack(input int t0, t1, t2, t3);
      return {6'(t3), 6'(t2), 6'(t1), 6'(t0)};
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int x, output int pc);
      int tries;
      tries   = 0;
      s_data  = 6'(x);
      s_valid = 1'b1;
      while (s_ready !== 1'b1 && tries < 16) begin
         @(posedge clk);
         #1;
         tries++;
      end
      vectors++;
      if (s_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL push_accept: s_ready=%b required 1 (sample %0d)", s_ready, x);
      end
      pc = cyc + 1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   // Checks the six programming cycles that follow a cfg_start edge, then
   // the first RUN cycle.
   task automatic check_prog_seq(input logic [23:0] c);
      logic [5:0] ex;
      logic       er;
      for (int k = 0; k < 6; k++) begin
         er = (k == 0);
         ex = (k < 2) ? 6'd0 : c[6*(5-k) +: 6];
         vectors++;
         if (fir_reset !== er) begin
            miscompares++;
            $display("FAIL prog_fir_reset[%0d]: got %b required %b", k, fir_reset, er);
         end
         vectors++;
         if (fir_x !== ex) begin
            miscompares++;
            $display("FAIL prog_fir_x[%0d]: got %h required %h", k, fir_x, ex);
         end
         vectors++;
         if (busy !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL prog_flags[%0d]: busy=%b s_ready=%b m_valid=%b required 1 0 0",
                     k, busy, s_ready, m_valid);
         end
         idle(1);
      end
      vectors++;
      if (busy !== 1'b0 || s_ready !== 1'b1 || fir_reset !== 1'b0) begin
         miscompares++;
         $display("FAIL prog_done: busy=%b s_ready=%b fir_reset=%b required 0 1 0",
                  busy, s_ready, fir_reset);
      end
   endtask

   task automatic program_taps(input int t0, t1, t2, t3);
      logic [23:0] c;
      c = pack(t0, t1, t2, t3);
      tp[0] = t0; tp[1] = t1; tp[2] = t2; tp[3] = t3;
      cfg_coef  = c;
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      check_prog_seq(c);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset_n = 1'b0;
      idle(2);
      vectors++;
      if (fir_reset !== 1'b1) begin miscompares++; $display("FAIL rst_fir_reset: got %b required 1", fir_reset); end
      vectors++;
      if (fir_x !== 6'd0) begin miscompares++; $display("FAIL rst_fir_x: got %h required 00", fir_x); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b required 0", busy); end
      vectors++;
      if (s_ready !== 1'b0) begin miscompares++; $display("FAIL rst_s_ready: got %b required 0", s_ready); end
      vectors++;
      if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_m_valid: got %b required 0", m_valid); end
      vectors++;
      if (m_data !== 8'h00) begin miscompares++; $display("FAIL rst_m_data: got %h required 00", m_data); end
      reset_n = 1'b1;
      idle(3);
      vectors++;
      if (busy !== 1'b0 || fir_reset !== 1'b1 || s_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_hold: busy=%b fir_reset=%b s_ready=%b required 0 1 0", busy, fir_reset, s_ready);
      end
   endtask

   task automatic test_program;
      // fir_x must read 0 (mode), 31, 0x38, 8, 16
      program_taps(16, 8, -8, 31);
      idle(5);
   endtask

   task automatic test_impulse(input logic [7:0] e0, e1, e2, e3, input string nm);
      int pc [4];
      logic [7:0] e [4];
      e = '{e0, e1, e2, e3};
      got_data.delete();
      got_cyc.delete();
      push(31, pc[0]);
      push(0,  pc[1]);
      push(0,  pc[2]);
      push(0,  pc[3]);
      idle(8);
      vectors++;
      if (got_data.size() != 4) begin
         miscompares++;
         $display("FAIL %s_count: got %0d results required 4", nm, got_data.size());
      end
      for (int i = 0; i < 4; i++) begin
         if (i < got_data.size()) begin
            vectors++;
            if (got_data[i] !== e[i]) begin
               miscompares++;
               $display("FAIL %s_data[%0d]: got %h required %h", nm, i, got_data[i], e[i]);
            end
            vectors++;
            if (got_cyc[i] != pc[i] + 3) begin
               miscompares++;
               $display("FAIL %s_latency[%0d]: got cycle %0d required %0d", nm, i, got_cyc[i], pc[i] + 3);
            end
         end
      end
   endtask

   task automatic test_corner;
      int pc [2];
      logic [7:0] e [2];
      e = '{8'h20, 8'hE1};
      program_taps(-32, 0, 0, 0);
      idle(5);
      got_data.delete();
      got_cyc.delete();
      push(-32, pc[0]);
      idle(6);
      push(31, pc[1]);
      idle(8);
      vectors++;
      if (got_data.size() != 2) begin
         miscompares++;
         $display("FAIL corner_count: got %0d results required 2", got_data.size());
      end
      for (int i = 0; i < 2; i++) begin
         if (i < got_data.size()) begin
            vectors++;
            if (got_data[i] !== e[i]) begin
               miscompares++;
               $display("FAIL corner_data[%0d]: got %h required %h", i, got_data[i], e[i]);
            end
            vectors++;
            if (got_cyc[i] != pc[i] + 3) begin
               miscompares++;
               $display("FAIL corner_latency[%0d]: got cycle %0d required %0d", i, got_cyc[i], pc[i] + 3);
            end
         end
      end
   endtask

   // Streams samples with a fixed gap of bubbles between pushes and checks
   // every result against the reference over the fed sequence.
   task automatic run_stream(input int smp [5], input int gap, input string nm);
      int pc [5];
      int ridx [5];
      logic [7:0] ex;
      fed.delete();
      got_data.delete();
      got_cyc.delete();
      for (int i = 0; i < 5; i++) begin
         ridx[i] = fed.size();
         fed.push_back(smp[i]);
         push(smp[i], pc[i]);
         if (i < 4) begin
            for (int g = 0; g < gap; g++) fed.push_back(0);
            idle(gap);
         end
      end
      idle(8);
      vectors++;
      if (got_data.size() != 5) begin
         miscompares++;
         $display("FAIL %s_count: got %0d results required 5", nm, got_data.size());
      end
      for (int i = 0; i < 5; i++) begin
         if (i < got_data.size()) begin
            ex = ref_at(ridx[i]);
            vectors++;
            if (got_data[i] !== ex) begin
               miscompares++;
               $display("FAIL %s_data[%0d]: got %h required %h", nm, i, got_data[i], ex);
            end
            vectors++;
            if (got_cyc[i] != pc[i] + 3) begin
               miscompares++;
               $display("FAIL %s_latency[%0d]: got cycle %0d required %0d", nm, i, got_cyc[i], pc[i] + 3);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int smp [5];
      program_taps(16, 8, -8, 31);
      idle(5);
      smp = '{5, -3, 12, -32, 31};
      run_stream(smp, 0, "b2b");
   endtask

   task automatic test_starvation;
      int smp [5];
      smp = '{7, -20, 25, -1, 13};
      run_stream(smp, 2, "starve");
   endtask

   task automatic test_restart;
      int pc;
      logic [23:0] c;
      got_data.delete();
      got_cyc.delete();
      push(10, pc);
      push(11, pc);
      push(12, pc);
      c = pack(10, -5, 3, -12);
      tp[0] = 10; tp[1] = -5; tp[2] = 3; tp[3] = -12;
      s_data    = 6'd13;
      s_valid   = 1'b1;
      cfg_coef  = c;
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      s_valid   = 1'b0;
      cfg_start = 1'b0;
      check_prog_seq(c);
      idle(6);
      vectors++;
      if (got_data.size() != 0) begin
         miscompares++;
         $display("FAIL restart_flush: got %0d results required 0", got_data.size());
      end
      // 31*10/32=9, 31*-5/32=-5, 31*3/32=2, 31*-12/32=-12
      test_impulse(8'h09, 8'hFB, 8'h02, 8'hF4, "restart_imp");
   endtask

   task automatic test_reset_mid_coef;
      cfg_coef  = pack(16, 8, -8, 31);
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      idle(3);
      vectors++;
      if (fir_x !== 6'h38 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midcoef_pre: fir_x=%h busy=%b required 38 1", fir_x, busy);
      end
      reset_n = 1'b0;
      idle(1);
      vectors++;
      if (fir_reset !== 1'b1 || fir_x !== 6'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midcoef_rst_core: fir_reset=%b fir_x=%h busy=%b required 1 00 0", fir_reset, fir_x, busy);
      end
      vectors++;
      if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
         miscompares++;
         $display("FAIL midcoef_rst_stream: s_ready=%b m_valid=%b m_data=%h required 0 0 00", s_ready, m_valid, m_data);
      end
      reset_n = 1'b1;
      idle(5);
      vectors++;
      if (busy !== 1'b0 || fir_reset !== 1'b1 || fir_x !== 6'd0 || s_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midcoef_idle: busy=%b fir_reset=%b fir_x=%h s_ready=%b required 0 1 00 0",
                  busy, fir_reset, fir_x, s_ready);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      reset_n   = 1'b0;
      cfg_coef  = '0;
      cfg_start = 1'b0;
      s_data    = '0;
      s_valid   = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_program();
      test_impulse(8'h0F, 8'h07, 8'hF8, 8'h1E, "impulse");
      test_corner();
      test_back_to_back();
      test_starvation();
      test_restart();
      test_reset_mid_coef();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
